button_debouncer: RTL and testbench

//   Conditions raw break-away PMOD buttons before they reach the button counter.
//   - Synchronises each asynchronous button input into the i_clock domain.
//   - Filters contact bounce and emits one-cycle press/release pulses per channel.
//   - Feeds o_press to the counter's inc/dec/reset inputs in place of the raw pins.
//

---
 rtl/button_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 168 ++++++++++++++++
 rtl/button_debouncer.sv | 36 +++
 tb/tb_button_debouncer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the button debouncer: repeat FSM states, counter
// width helper and default timing for the 12 MHz board clock.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } repeat_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 120000;   // 10 ms @ 12 MHz
    localparam int DEF_REPEAT_DELAY    = 6000000;  // 500 ms @ 12 MHz
    localparam int DEF_REPEAT_PERIOD   = 1200000;  // 100 ms @ 12 MHz

    // Bits needed to hold values 0..max_count; never narrower than one bit.
    function automatic int count_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, bounce filter, press/release
// pulse generation and, when BUTTON_DEBOUNCER_REPEAT_EN is defined, an
// auto-repeat FSM that adds extra press pulses while the button is held.
//
// Repeat FSM states (BUTTON_DEBOUNCER_REPEAT_EN builds only):
//   state  | meaning
//   IDLE   | button released, nothing scheduled
//   DELAY  | press accepted, waiting REPEAT_DELAY cycles for first repeat
//   REPEAT | repeating every REPEAT_PERIOD cycles while held
module debounce_channel
    import button_pkg::*;
#(
    parameter bit PRESSED_LEVEL   = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_button,
    output logic o_state,
    output logic o_press,
    output logic o_release
);

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    localparam bit REPEAT_ENABLED = 1'b1;
`else
    localparam bit REPEAT_ENABLED = 1'b0;
`endif

    localparam int                CNT_W    = count_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject timing values that would make the filter or repeat timer meaningless.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_ENABLED && (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)) begin : g_bad_repeat
        $error("debounce_channel: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             state_q, state_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic s_pressed;
    logic accept_press;
    logic accept_release;
    logic repeat_pulse;

    // Synchroniser and filter next-state: count consecutive mismatches, accept on the last.
    always_comb begin
        sync1_d        = i_button;
        sync2_d        = sync1_q;
        s_pressed      = ~(sync2_q ^ PRESSED_LEVEL);
        state_d        = state_q;
        cnt_d          = cnt_q;
        accept_press   = 1'b0;
        accept_release = 1'b0;
        if (s_pressed == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            state_d        = s_pressed;
            cnt_d          = '0;
            accept_press   = s_pressed;
            accept_release = ~s_pressed;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    localparam int               TMR_W       = count_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                           REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    repeat_state_e    rstate_q, rstate_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    // Repeat FSM next-state; an accepted release always returns to IDLE.
    always_comb begin
        rstate_d     = rstate_q;
        timer_d      = timer_q;
        repeat_pulse = 1'b0;
        case (rstate_q)
            IDLE: begin
                if (accept_press) begin
                    rstate_d = DELAY;
                    timer_d  = '0;
                end
            end
            DELAY: begin
                if (timer_q == DELAY_LAST) begin
                    rstate_d     = REPEAT;
                    timer_d      = '0;
                    repeat_pulse = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            REPEAT: begin
                if (timer_q == PERIOD_LAST) begin
                    timer_d      = '0;
                    repeat_pulse = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                rstate_d = IDLE;
                timer_d  = '0;
            end
        endcase
        if (accept_release) begin
            rstate_d = IDLE;
            timer_d  = '0;
        end
    end

    // Repeat FSM state and timer registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rstate_q <= IDLE;
            timer_q  <= '0;
        end else begin
            rstate_q <= rstate_d;
            timer_q  <= timer_d;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

    // Output pulses: a release accepted in the same cycle suppresses a due repeat.
    always_comb begin
        press_d   = accept_press | (repeat_pulse & ~accept_release);
        release_d = accept_release;
    end

    // Synchroniser, filter and pulse registers; sync flops reset to the released level.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync1_q   <= ~PRESSED_LEVEL;
            sync2_q   <= ~PRESSED_LEVEL;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_state   = state_q;
    assign o_press   = press_q;
    assign o_release = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Button debouncer top: CHANNELS independent debounce_channel instances.
// Define BUTTON_DEBOUNCER_REPEAT_EN to build in per-channel auto-repeat.
module button_debouncer
    import button_pkg::*;
#(
    parameter int CHANNELS        = 3,
    parameter bit PRESSED_LEVEL   = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [CHANNELS-1:0] i_buttons,
    output logic [CHANNELS-1:0] o_state,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_channel #(
            .PRESSED_LEVEL   (PRESSED_LEVEL),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .i_clock   (i_clock),
            .i_reset   (i_reset),
            .i_button  (i_buttons[g]),
            .o_state   (o_state[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with short timing (D=4, delay=10, period=3).
module tb_button_debouncer;

    localparam int CH = 3;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          i_reset;
    logic [CH-1:0] i_buttons;
    logic [CH-1:0] o_state, o_press, o_release;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    button_debouncer #(
        .CHANNELS        (CH),
        .PRESSED_LEVEL   (1'b1),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .i_clock   (clk),
        .i_reset   (i_reset),
        .i_buttons (i_buttons),
        .o_state   (o_state),
        .o_press   (o_press),
        .o_release (o_release)
    );

    always #5 clk = ~clk;

    // Reference model: sq[ch][k] holds the pressed-level pin sample taken k+1 edges ago.
    // A change is accepted when the D most recent synchronised samples all disagree
    // with the debounced level; repeats are scheduled by age since the accepted press.
    bit            sq[CH][8];
    bit            m_state[CH];
    int            t_acc[CH];
    logic [CH-1:0] exp_state   = '0;
    logic [CH-1:0] exp_press   = '0;
    logic [CH-1:0] exp_release = '0;
    bit            all_diff;
    int            age;

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int ch = 0; ch < CH; ch++) begin
            if (i_reset) begin
                m_state[ch]     = 1'b0;
                exp_state[ch]   = 1'b0;
                exp_press[ch]   = 1'b0;
                exp_release[ch] = 1'b0;
                for (int k = 0; k < 8; k++) sq[ch][k] = 1'b0;
            end else begin
                all_diff = 1'b1;
                for (int k = 1; k <= D; k++)
                    if (sq[ch][k] == m_state[ch]) all_diff = 1'b0;
                exp_press[ch]   = 1'b0;
                exp_release[ch] = 1'b0;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
                if (m_state[ch]) begin
                    age = cyc - t_acc[ch];
                    if (age == RD || (age > RD && (age - RD) % RP == 0))
                        exp_press[ch] = 1'b1;
                end
`endif
                if (all_diff) begin
                    m_state[ch] = ~m_state[ch];
                    if (m_state[ch]) begin
                        exp_press[ch] = 1'b1;
                        t_acc[ch]     = cyc;
                    end else begin
                        exp_press[ch]   = 1'b0;
                        exp_release[ch] = 1'b1;
                    end
                end
                exp_state[ch] = m_state[ch];
                for (int k = 7; k > 0; k--) sq[ch][k] = sq[ch][k-1];
                sq[ch][0] = (i_buttons[ch] == 1'b1);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            total = total + 1;
            if (o_state !== exp_state || o_press !== exp_press || o_release !== exp_release) begin
                bad = bad + 1;
                $display("FAIL model_compare cyc=%0d state=%b/%b press=%b/%b release=%b/%b",
                         cyc, o_state, exp_state, o_press, exp_press, o_release, exp_release);
            end
        end
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        total = total + 1;
        if (act != req) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Wait (bounded) for a press pulse on any channel of mask; returns latency or -1.
    task automatic wait_press(input logic [CH-1:0] mask, input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((o_press & mask) != '0) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic wait_release(input logic [CH-1:0] mask, input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((o_release & mask) != '0) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    int lat;
    int t0;
    int seen;
    int base;
    int off;
    int rel_off;
    int offs[$];
    int exp_offs[];
    bit bounce_seq[];

    initial begin
        i_reset   = 1'b1;
        i_buttons = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({o_state, o_press, o_release}), 0);
        i_reset = 1'b0;

        // 1: idle after reset
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if ({o_state, o_press, o_release} != '0) seen = 1;
        end
        chk("idle_20_cycles", seen, 0);

        // 2: clean press on ch0
        i_buttons[0] = 1'b1;
        t0 = cyc;
        wait_press(3'b001, t0, lat);
        chk("press_latency", lat, 6);
        chk("press_state", int'(o_state[0]), 1);
        @(negedge clk);
        chk("press_single_cycle", int'(o_press[0]), 0);
        i_buttons[0] = 1'b0;
        t0 = cyc;
        wait_release(3'b001, t0, lat);
        chk("release_latency", lat, 6);
        chk("release_state", int'(o_state[0]), 0);
        repeat (5) @(negedge clk);

        // 3: bounce on ch1
        bounce_seq = '{1, 1, 1, 0, 1, 1, 1, 0};
        seen = 0;
        foreach (bounce_seq[i]) begin
            i_buttons[1] = bounce_seq[i];
            @(negedge clk);
            if (o_press[1] || o_state[1]) seen = 1;
        end
        repeat (10) begin
            @(negedge clk);
            if (o_press[1] || o_state[1]) seen = 1;
        end
        chk("bounce_rejected", seen, 0);

        // 4: simultaneous press and release on ch0 and ch2
        i_buttons = 3'b101;
        t0 = cyc;
        wait_press(3'b111, t0, lat);
        chk("simul_press_latency", lat, 6);
        chk("simul_press_mask", int'(o_press), 5);
        i_buttons = 3'b000;
        t0 = cyc;
        wait_release(3'b111, t0, lat);
        chk("simul_release_latency", lat, 6);
        chk("simul_release_mask", int'(o_release), 5);
        repeat (5) @(negedge clk);

        // 5: reset while ch1 is mid-count (cnt = 2)
        i_buttons[1] = 1'b1;
        repeat (4) @(negedge clk);
        i_reset = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_press != '0 || o_release != '0) seen = 1;
        end
        chk("reset_mid_count_no_pulse", seen, 0);
        i_reset = 1'b0;
        t0 = cyc;
        wait_press(3'b010, t0, lat);
        chk("held_through_reset_latency", lat, 6);
        i_buttons[1] = 1'b0;
        t0 = cyc;
        wait_release(3'b010, t0, lat);
        chk("held_release_latency", lat, 6);
        repeat (5) @(negedge clk);

        // 6: hold ch0 for 30 cycles after its accepted press
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
        exp_offs = '{0, 10, 13, 16, 19, 22, 25, 28, 31, 34};
`else
        exp_offs = '{0};
`endif
        i_buttons[0] = 1'b1;
        t0 = cyc;
        wait_press(3'b001, t0, lat);
        chk("hold_press_latency", lat, 6);
        base    = cyc;
        rel_off = -1;
        offs.delete();
        offs.push_back(0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            off = cyc - base;
            if (o_press[0]) offs.push_back(off);
            if (o_release[0]) begin
                rel_off = off;
                break;
            end
            if (off == 30) i_buttons[0] = 1'b0;
        end
        chk("hold_pulse_count", offs.size(), exp_offs.size());
        for (int i = 0; i < exp_offs.size() && i < offs.size(); i++)
            chk("hold_pulse_offset", offs[i], exp_offs[i]);
        chk("hold_release_offset", rel_off, 36);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (o_press != '0) seen = 1;
        end
        chk("no_press_after_release", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
